// File: rtl/rectify_scan_ctrl.sv
// rectify_scan_ctrl
// Drives the read side of the Fetch line/frame buffer for one rectified output
// frame. Once an input frame has been completely written it raster-scans the
// OUT_W x OUT_H output grid. For each output pixel it reads an integer source
// offset from an external remap LUT and issues a clamped Fetch read
// coordinate. The valid flag and the frame/line tags are then delayed to line
// up with the Fetch data. Issue is paced by a credit counter that mirrors the
// free space in the downstream FIFO.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   in_tvalid/in_flast  input write strobe / last pixel of the input frame
//   map_addr            remap LUT address (registered at issue)
//   map_xint/map_yint   signed LUT offsets, sampled the cycle after issue
//   rx, ry, fetch_en    clamped Fetch read coordinate and its strobe
//   credit_ret          one pulse per beat popped downstream
//   out_tvalid          Fetch data valid (fetch_en delayed by FETCH_LAT)
//   out_tuser/tlast/eof start of frame / end of line / end of frame tags
//   out_oob             the beat's source coordinate was clamped
//   busy                a scan is in progress
//   ovf                 sticky: an input frame completed while one was pending
module rectify_scan_ctrl #(
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 10,
  parameter int OUT_W     = 7,
  parameter int OUT_H     = 5,
  parameter int FETCH_LAT = 2,
  parameter int CREDITS   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_tvalid,
  input  logic                               in_flast,
  output logic [$clog2(OUT_W*OUT_H)-1:0]     map_addr,
  input  logic [9:0]                         map_xint,
  input  logic [9:0]                         map_yint,
  output logic [9:0]                         rx,
  output logic [9:0]                         ry,
  output logic                               fetch_en,
  input  logic                               credit_ret,
  output logic                               out_tvalid,
  output logic                               out_tuser,
  output logic                               out_tlast,
  output logic                               out_eof,
  output logic                               out_oob,
  output logic                               busy,
  output logic                               ovf
);

  localparam int AW = $clog2(OUT_W*OUT_H);
  localparam int CW = $clog2(CREDITS+1);
  localparam logic signed [10:0] X_MAX = 11'(IMG_W-2);
  localparam logic signed [10:0] Y_MAX = 11'(IMG_H-2);

  // Beat word carried through the output delay line.
  localparam int B_VLD = 4;
  localparam int B_OOB = 3;
  localparam int B_SOF = 2;
  localparam int B_EOL = 1;
  localparam int B_EOF = 0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [9:0]      ox, oy;
  logic [AW-1:0]   addr_cnt;
  logic [AW-1:0]   map_addr_reg;
  logic [CW-1:0]   credits;
  logic            pending;
  logic            ovf_reg;
  logic            busy_reg;

  // Stage 0: the cycle map_addr is presented to the LUT.
  logic            s0_valid, s0_sof, s0_eol, s0_eof;
  logic [9:0]      s0_ox, s0_oy;

  // Stage 1: clamped coordinate registered towards Fetch.
  logic [4:0]      s1_beat;
  logic [9:0]      rx_reg, ry_reg;

  logic [4:0]      beat_pipe [FETCH_LAT];

  logic            issue;
  logic            flast_hit;
  logic            last_col, last_row;
  logic            pipe_busy;
  logic signed [10:0] sx, sy;
  logic            x_clamped, y_clamped;
  logic [9:0]      cx, cy;

  assign issue     = (state == RUN) && (credits != '0);
  assign flast_hit = in_tvalid & in_flast;
  assign last_col  = (ox == 10'(OUT_W-1));
  assign last_row  = (oy == 10'(OUT_H-1));

  // Source coordinate in 11-bit signed arithmetic, then clamped so that the
  // 2x2 neighbourhood read by Fetch stays inside the input frame.
  assign sx = $signed({1'b0, s0_ox}) + $signed({map_xint[9], map_xint});
  assign sy = $signed({1'b0, s0_oy}) + $signed({map_yint[9], map_yint});

  always_comb begin
    x_clamped = 1'b0;
    y_clamped = 1'b0;
    cx        = sx[9:0];
    cy        = sy[9:0];
    if (sx < 11'sd0) begin
      x_clamped = 1'b1;
      cx        = '0;
    end else if (sx > X_MAX) begin
      x_clamped = 1'b1;
      cx        = X_MAX[9:0];
    end
    if (sy < 11'sd0) begin
      y_clamped = 1'b1;
      cy        = '0;
    end else if (sy > Y_MAX) begin
      y_clamped = 1'b1;
      cy        = Y_MAX[9:0];
    end
  end

  // Any beat still travelling between issue and out_tvalid.
  always_comb begin
    pipe_busy = s0_valid | s1_beat[B_VLD];
    for (int i = 0; i < FETCH_LAT; i++) begin
      pipe_busy = pipe_busy | beat_pipe[i][B_VLD];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ox           <= '0;
      oy           <= '0;
      addr_cnt     <= '0;
      map_addr_reg <= '0;
      credits      <= CW'(CREDITS);
      pending      <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      s0_valid     <= 1'b0;
      s0_sof       <= 1'b0;
      s0_eol       <= 1'b0;
      s0_eof       <= 1'b0;
      s0_ox        <= '0;
      s0_oy        <= '0;
      s1_beat      <= '0;
      rx_reg       <= '0;
      ry_reg       <= '0;
    end else begin
      // Frame-completion tracking. A new completion wins over the clear on
      // IDLE->RUN, so a frame finishing in that same cycle is not lost.
      if (flast_hit) begin
        if (pending) begin
          ovf_reg <= 1'b1;
        end
        pending <= 1'b1;
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end

      // Credits: a returned credit is ignored when the counter is full.
      if (issue && !credit_ret) begin
        credits <= credits - CW'(1);
      end else if (!issue && credit_ret && credits != CW'(CREDITS)) begin
        credits <= credits + CW'(1);
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state    <= RUN;
            busy_reg <= 1'b1;
            ox       <= '0;
            oy       <= '0;
            addr_cnt <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            map_addr_reg <= addr_cnt;
            addr_cnt     <= addr_cnt + AW'(1);
            if (last_col) begin
              ox <= '0;
              oy <= last_row ? '0 : oy + 10'd1;
              if (last_row) begin
                state <= DRAIN;
              end
            end else begin
              ox <= ox + 10'd1;
            end
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase

      s0_valid <= issue;
      s0_ox    <= ox;
      s0_oy    <= oy;
      s0_sof   <= issue && ox == '0 && oy == '0;
      s0_eol   <= issue && last_col;
      s0_eof   <= issue && last_col && last_row;

      if (s0_valid) begin
        rx_reg  <= cx;
        ry_reg  <= cy;
        s1_beat <= {1'b1, x_clamped | y_clamped, s0_sof, s0_eol, s0_eof};
      end else begin
        s1_beat <= '0;
      end
    end
  end

  // Delay line matching the Fetch read latency.
  generate
    for (genvar gi = 0; gi < FETCH_LAT; gi++) begin : g_lat
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            beat_pipe[gi] <= '0;
          end else begin
            beat_pipe[gi] <= s1_beat;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) begin
            beat_pipe[gi] <= '0;
          end else begin
            beat_pipe[gi] <= beat_pipe[gi-1];
          end
        end
      end
    end
  endgenerate

  assign map_addr   = map_addr_reg;
  assign rx         = rx_reg;
  assign ry         = ry_reg;
  assign fetch_en   = s1_beat[B_VLD];
  assign out_tvalid = beat_pipe[FETCH_LAT-1][B_VLD];
  assign out_oob    = beat_pipe[FETCH_LAT-1][B_OOB];
  assign out_tuser  = beat_pipe[FETCH_LAT-1][B_SOF];
  assign out_tlast  = beat_pipe[FETCH_LAT-1][B_EOL];
  assign out_eof    = beat_pipe[FETCH_LAT-1][B_EOF];
  assign busy       = busy_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_rectify_scan_ctrl.sv
// Testbench for rectify_scan_ctrl. A transaction-level model schedules every
// expected Fetch read and output beat at its due cycle. A negedge process
// compares all DUT outputs against that schedule on every cycle. The directed
// scenarios add literal expectations for specific beats.
module tb_rectify_scan_ctrl;

  localparam int IMG_W     = 16;
  localparam int IMG_H     = 10;
  localparam int OUT_W     = 7;
  localparam int OUT_H     = 5;
  localparam int FETCH_LAT = 2;
  localparam int CREDITS   = 4;
  localparam int NPIX      = OUT_W*OUT_H;
  localparam int AW        = $clog2(NPIX);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_tvalid = 1'b0;
  logic in_flast = 1'b0;
  logic tie_ret = 1'b0;
  logic ret_pulse = 1'b0;
  logic credit_ret;
  logic [AW-1:0] map_addr;
  logic [9:0] map_xint, map_yint;
  logic [9:0] rx, ry;
  logic fetch_en, out_tvalid, out_tuser, out_tlast, out_eof, out_oob, busy, ovf;

  logic signed [9:0] lut_x [64];
  logic signed [9:0] lut_y [64];

  always #5 clk = ~clk;

  // The LUT answers for the registered address it is being shown.
  assign map_xint   = lut_x[map_addr];
  assign map_yint   = lut_y[map_addr];
  assign credit_ret = (tie_ret & out_tvalid) | ret_pulse;

  rectify_scan_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H),
    .FETCH_LAT(FETCH_LAT), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_flast(in_flast),
    .map_addr(map_addr), .map_xint(map_xint), .map_yint(map_yint),
    .rx(rx), .ry(ry), .fetch_en(fetch_en), .credit_ret(credit_ret),
    .out_tvalid(out_tvalid), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_eof(out_eof), .out_oob(out_oob), .busy(busy), .ovf(ovf)
  );

  typedef struct packed {
    logic [9:0] rx;
    logic [9:0] ry;
    logic oob;
    logic sof;
    logic eol;
    logic eof;
  } beat_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  beat_t fetch_sched [int];
  beat_t out_sched [int];
  beat_t cap_f [$];
  beat_t cap_o [$];
  int    cap_fcyc [$];
  int    cap_ocyc [$];

  int cyc = 0;
  bit model_on = 0;
  bit m_busy, m_pending, m_ovf;
  int m_credits, m_issued, m_scan_end, m_addr;

  always @(negedge clk) begin
    beat_t eb;
    bit ef, eo, iss, start, fin, setp;
    int ox, oy, sx, sy;
    if (model_on) begin
      ef = fetch_sched.exists(cyc);
      eo = out_sched.exists(cyc);
      chk("busy", busy, m_busy);
      chk("ovf", ovf, m_ovf);
      chk("map_addr", map_addr, m_addr);
      chk("fetch_en", fetch_en, ef);
      if (ef) begin
        eb = fetch_sched[cyc];
        chk("rx", rx, eb.rx);
        chk("ry", ry, eb.ry);
        fetch_sched.delete(cyc);
      end
      chk("out_tvalid", out_tvalid, eo);
      eb = eo ? out_sched[cyc] : '0;
      chk("out_oob", out_oob, eb.oob);
      chk("out_tuser", out_tuser, eb.sof);
      chk("out_tlast", out_tlast, eb.eol);
      chk("out_eof", out_eof, eb.eof);
      if (eo) out_sched.delete(cyc);
      if (fetch_en === 1'b1) begin
        eb = '0; eb.rx = rx; eb.ry = ry;
        cap_f.push_back(eb); cap_fcyc.push_back(cyc);
      end
      if (out_tvalid === 1'b1) begin
        eb = '0; eb.oob = out_oob; eb.sof = out_tuser; eb.eol = out_tlast; eb.eof = out_eof;
        cap_o.push_back(eb); cap_ocyc.push_back(cyc);
      end
    end

    if (rst) begin
      model_on   = 1;
      m_busy     = 0;
      m_pending  = 0;
      m_ovf      = 0;
      m_credits  = CREDITS;
      m_issued   = 0;
      m_scan_end = -1;
      m_addr     = 0;
      fetch_sched.delete();
      out_sched.delete();
    end else if (model_on) begin
      iss = m_busy && m_issued < NPIX && m_credits > 0;
      if (iss) begin
        ox = m_issued % OUT_W;
        oy = m_issued / OUT_W;
        sx = ox + int'(lut_x[m_issued]);
        sy = oy + int'(lut_y[m_issued]);
        eb = '0;
        if (sx < 0) begin sx = 0; eb.oob = 1; end
        if (sx > IMG_W-2) begin sx = IMG_W-2; eb.oob = 1; end
        if (sy < 0) begin sy = 0; eb.oob = 1; end
        if (sy > IMG_H-2) begin sy = IMG_H-2; eb.oob = 1; end
        eb.rx  = 10'(sx);
        eb.ry  = 10'(sy);
        eb.sof = (m_issued == 0);
        eb.eol = (ox == OUT_W-1);
        eb.eof = (m_issued == NPIX-1);
        fetch_sched[cyc+2] = eb;
        out_sched[cyc+2+FETCH_LAT] = eb;
        m_addr = m_issued;
        m_issued++;
        if (m_issued == NPIX) m_scan_end = cyc + FETCH_LAT + 4;
      end
      if (iss && !credit_ret) m_credits--;
      else if (!iss && credit_ret && m_credits < CREDITS) m_credits++;
      start = !m_busy && m_pending;
      fin   = m_busy && m_issued == NPIX && (cyc + 1 == m_scan_end);
      setp  = in_tvalid && in_flast;
      if (setp && m_pending) m_ovf = 1;
      if (setp) m_pending = 1;
      else if (start) m_pending = 0;
      if (start) begin
        m_busy = 1;
        m_issued = 0;
      end else if (fin) begin
        m_busy = 0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_caps();
    cap_f.delete(); cap_o.delete(); cap_fcyc.delete(); cap_ocyc.delete();
  endtask

  task automatic pulse_flast();
    @(posedge clk); #1; in_tvalid = 1; in_flast = 1;
    @(posedge clk); #1; in_tvalid = 0; in_flast = 0;
  endtask

  task automatic wait_busy(input logic val, input int bound, input string nm);
    int k = 0;
    while (busy !== val && k < bound) begin
      @(negedge clk); k++;
    end
    chk(nm, busy, val);
  endtask

  task automatic set_lut(input int xo, input int yo);
    for (int i = 0; i < 64; i++) begin
      lut_x[i] = 10'(xo);
      lut_y[i] = 10'(yo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k, eolc, eofc;
    set_lut(3, -2);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_out_tvalid", out_tvalid, 0);

    // Scenario 1: full input frame, constant offsets (+3,-2), credits tied.
    tie_ret = 1;
    clear_caps();
    for (int i = 1; i <= 160; i++) begin
      @(posedge clk); #1;
      in_tvalid = 1;
      in_flast  = (i == 160);
    end
    @(posedge clk); #1; in_tvalid = 0; in_flast = 0;
    chk("s1_busy_f1", busy, 0);
    @(posedge clk); #1;
    chk("s1_busy_f2", busy, 1);
    wait_busy(0, 1000, "s1_done");
    chk("s1_nfetch", cap_f.size(), 35);
    chk("s1_nout", cap_o.size(), 35);
    if (cap_o.size() == 35 && cap_f.size() == 35) begin
      chk("s1_first_sof", cap_o[0].sof, 1);
      chk("s1_b0_rx", cap_f[0].rx, 3);
      chk("s1_b0_ry", cap_f[0].ry, 0);
      chk("s1_b0_oob", cap_o[0].oob, 1);
      chk("s1_b34_rx", cap_f[34].rx, 9);
      chk("s1_b34_ry", cap_f[34].ry, 2);
      chk("s1_b34_oob", cap_o[34].oob, 0);
      chk("s1_b34_eof", cap_o[34].eof, 1);
      chk("s1_lat", cap_ocyc[0] - cap_fcyc[0], 2);
      eolc = 0; eofc = 0;
      for (int i = 0; i < 35; i++) begin
        eolc += int'(cap_o[i].eol);
        eofc += int'(cap_o[i].eof);
        if (i == 6 || i == 13 || i == 20 || i == 27 || i == 34)
          chk("s1_eol_pos", cap_o[i].eol, 1);
      end
      chk("s1_eol_count", eolc, 5);
      chk("s1_eof_count", eofc, 1);
    end

    // Scenario 2: +12 x offset at ox=6 is clamped to IMG_W-2.
    set_lut(0, 0);
    lut_x[6] = 10'sd12;
    clear_caps();
    pulse_flast();
    wait_busy(1, 20, "s2_start");
    wait_busy(0, 1000, "s2_done");
    chk("s2_nfetch", cap_f.size(), 35);
    if (cap_f.size() == 35 && cap_o.size() == 35) begin
      chk("s2_b6_rx", cap_f[6].rx, 14);
      chk("s2_b6_ry", cap_f[6].ry, 0);
      chk("s2_b6_oob", cap_o[6].oob, 1);
      chk("s2_b5_rx", cap_f[5].rx, 5);
      chk("s2_b5_oob", cap_o[5].oob, 0);
    end

    // Scenario 3: no credits returned -> exactly CREDITS issues.
    tie_ret = 0;
    clear_caps();
    pulse_flast();
    repeat (40) @(negedge clk);
    chk("s3_four_issued", cap_f.size(), 4);
    @(posedge clk); #1 ret_pulse = 1;
    @(posedge clk); #1 ret_pulse = 0;
    repeat (20) @(negedge clk);
    chk("s3_one_more", cap_f.size(), 5);
    tie_ret = 1;
    @(posedge clk); #1 ret_pulse = 1;
    @(posedge clk); #1 ret_pulse = 0;
    wait_busy(0, 3000, "s3_done");
    chk("s3_total", cap_f.size(), 35);

    // Scenario 4: random offsets, random writes and spare credit pulses;
    // two extra completions during the scan set ovf and queue a second scan.
    for (int i = 0; i < 64; i++) begin
      lut_x[i] = 10'(int'($urandom_range(40)) - 20);
      lut_y[i] = 10'(int'($urandom_range(30)) - 15);
    end
    clear_caps();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_tvalid = (c == 0 || c == 10 || c == 15) ? 1'b1 : 1'($urandom_range(1));
      in_flast  = (c == 0 || c == 10 || c == 15);
      ret_pulse = ($urandom_range(7) == 0);
    end
    @(posedge clk); #1; in_tvalid = 0; in_flast = 0; ret_pulse = 0;
    chk("s4_ovf", ovf, 1);
    chk("s4_two_scans", cap_f.size(), 70);
    chk("s4_idle", busy, 0);

    // Scenario 5: reset after the 10th read of a scan aborts everything.
    set_lut(3, -2);
    clear_caps();
    pulse_flast();
    k = 0;
    while (cap_f.size() < 10 && k < 200) begin
      @(negedge clk); k++;
    end
    chk("s5_reach10", cap_f.size(), 10);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("s5_busy", busy, 0);
    chk("s5_fetch_en", fetch_en, 0);
    chk("s5_out_tvalid", out_tvalid, 0);
    chk("s5_rx", rx, 0);
    chk("s5_ry", ry, 0);
    chk("s5_map_addr", map_addr, 0);
    chk("s5_ovf", ovf, 0);
    n0 = cap_o.size();
    repeat (20) @(negedge clk);
    chk("s5_no_out", cap_o.size(), n0);
    chk("s5_still_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
